// File: rtl/dda_stepper.sv
// Iterative DDA ray-march stepper: advances the nearer grid boundary with
// saturating adds, queries the maze map per step, reports hit or timeout.
module dda_stepper #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int MAP_BITS   = 5,
  parameter int MAX_STEPS  = 64
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [MAP_BITS-1:0] map_x_in,
  input  logic [MAP_BITS-1:0] map_y_in,
  input  logic                step_x_in,
  input  logic                step_y_in,
  input  logic [WIDTH-1:0]    side_dist_x_in,
  input  logic [WIDTH-1:0]    side_dist_y_in,
  input  logic [WIDTH-1:0]    delta_dist_x_in,
  input  logic [WIDTH-1:0]    delta_dist_y_in,
  output logic                map_req_valid,
  output logic [MAP_BITS-1:0] map_addr_x,
  output logic [MAP_BITS-1:0] map_addr_y,
  input  logic                map_rsp_valid,
  input  logic [3:0]          map_rsp_cell,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [MAP_BITS-1:0] hit_x,
  output logic [MAP_BITS-1:0] hit_y,
  output logic                hit_side,
  output logic [3:0]          hit_cell,
  output logic [WIDTH-1:0]    perp_dist,
  output logic                timeout,
  output logic                ovrflw
);

  // The datapath is format-agnostic; the fractional split only has to fit.
  if (FRAC_WIDTH >= WIDTH) begin : g_frac_check
    $error("FRAC_WIDTH must be smaller than WIDTH");
  end

  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_STEPS);
  localparam logic [WIDTH-1:0]    SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]    SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MAP_BITS-1:0] INC_ONE = MAP_BITS'(1);
  localparam logic [MAP_BITS-1:0] DEC_ONE = '1;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_LOOKUP, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     side_x, side_y, delta_x, delta_y, perp_cand;
  logic [MAP_BITS-1:0]  map_x, map_y;
  logic                 step_x, step_y;
  logic [CNT_W-1:0]     step_cnt;

  logic                 step_is_x;
  logic [WIDTH-1:0]     sel_side, sel_delta, sat_val;
  logic [WIDTH:0]       sum;
  logic                 clip;

  // Ties step Y; the sum is formed one bit wider so overflow shows as a sign mismatch.
  always_comb begin
    step_is_x = $signed(side_x) < $signed(side_y);
    sel_side  = step_is_x ? side_x  : side_y;
    sel_delta = step_is_x ? delta_x : delta_y;
    sum       = {sel_side[WIDTH-1], sel_side} + {sel_delta[WIDTH-1], sel_delta};
    clip      = sum[WIDTH] ^ sum[WIDTH-1];
    sat_val   = sum[WIDTH-1:0];
    if (clip) sat_val = sum[WIDTH] ? SAT_MIN : SAT_MAX;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_valid) state_nxt = S_STEP;
      S_STEP:   state_nxt = S_LOOKUP;
      S_LOOKUP: if (map_rsp_valid) begin
                  if (map_rsp_cell != 4'd0 || step_cnt == CNT_MAX) state_nxt = S_DONE;
                  else                                             state_nxt = S_STEP;
                end
      S_DONE:   if (result_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_IDLE;
      side_x        <= '0;
      side_y        <= '0;
      delta_x       <= '0;
      delta_y       <= '0;
      perp_cand     <= '0;
      map_x         <= '0;
      map_y         <= '0;
      step_x        <= 1'b0;
      step_y        <= 1'b0;
      step_cnt      <= '0;
      map_req_valid <= 1'b0;
      hit_side      <= 1'b0;
      hit_cell      <= '0;
      timeout       <= 1'b0;
      ovrflw        <= 1'b0;
    end else begin
      state         <= state_nxt;
      map_req_valid <= 1'b0;
      case (state)
        S_IDLE: if (start_valid) begin
          side_x   <= side_dist_x_in;
          side_y   <= side_dist_y_in;
          delta_x  <= delta_dist_x_in;
          delta_y  <= delta_dist_y_in;
          map_x    <= map_x_in;
          map_y    <= map_y_in;
          step_x   <= step_x_in;
          step_y   <= step_y_in;
          step_cnt <= '0;
          ovrflw   <= 1'b0;
          timeout  <= 1'b0;
          hit_cell <= '0;
        end
        S_STEP: begin
          perp_cand     <= sel_side;
          step_cnt      <= step_cnt + CNT_W'(1);
          map_req_valid <= 1'b1;
          if (clip) ovrflw <= 1'b1;
          if (step_is_x) begin
            side_x   <= sat_val;
            map_x    <= map_x + (step_x ? DEC_ONE : INC_ONE);
            hit_side <= 1'b0;
          end else begin
            side_y   <= sat_val;
            map_y    <= map_y + (step_y ? DEC_ONE : INC_ONE);
            hit_side <= 1'b1;
          end
        end
        S_LOOKUP: if (map_rsp_valid) begin
          if (map_rsp_cell != 4'd0)   hit_cell <= map_rsp_cell;
          else if (step_cnt == CNT_MAX) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready  = (state == S_IDLE);
  assign result_valid = (state == S_DONE);
  assign map_addr_x   = map_x;
  assign map_addr_y   = map_y;
  assign hit_x        = map_x;
  assign hit_y        = map_y;
  assign perp_dist    = perp_cand;

endmodule

// File: tb/tb_dda_stepper.sv
// Bench for dda_stepper: maze model with configurable lookup latency and an
// arithmetic ray-march reference checked on every meaningful cycle.
module tb_dda_stepper;
  localparam int W    = 16;
  localparam int MB   = 5;
  localparam int MAXS = 64;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_valid, start_ready;
  logic [MB-1:0] map_x_in, map_y_in;
  logic          step_x_in, step_y_in;
  logic [W-1:0]  side_dist_x_in, side_dist_y_in, delta_dist_x_in, delta_dist_y_in;
  logic          map_req_valid;
  logic [MB-1:0] map_addr_x, map_addr_y;
  logic          map_rsp_valid;
  logic [3:0]    map_rsp_cell;
  logic          result_valid, result_ready;
  logic [MB-1:0] hit_x, hit_y;
  logic          hit_side;
  logic [3:0]    hit_cell;
  logic [W-1:0]  perp_dist;
  logic          timeout, ovrflw;

  always #5 clk_in = ~clk_in;

  dda_stepper #(.WIDTH(W), .FRAC_WIDTH(8), .MAP_BITS(MB), .MAX_STEPS(MAXS)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .start_valid(start_valid), .start_ready(start_ready),
    .map_x_in(map_x_in), .map_y_in(map_y_in),
    .step_x_in(step_x_in), .step_y_in(step_y_in),
    .side_dist_x_in(side_dist_x_in), .side_dist_y_in(side_dist_y_in),
    .delta_dist_x_in(delta_dist_x_in), .delta_dist_y_in(delta_dist_y_in),
    .map_req_valid(map_req_valid), .map_addr_x(map_addr_x), .map_addr_y(map_addr_y),
    .map_rsp_valid(map_rsp_valid), .map_rsp_cell(map_rsp_cell),
    .result_valid(result_valid), .result_ready(result_ready),
    .hit_x(hit_x), .hit_y(hit_y), .hit_side(hit_side), .hit_cell(hit_cell),
    .perp_dist(perp_dist), .timeout(timeout), .ovrflw(ovrflw)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // Maze memory; lat 0 answers in the request cycle (one-cycle lookup).
  logic [3:0] maze [32][32];
  int         map_lat = 0;
  logic       pend = 1'b0;
  int         pcnt = 0;
  logic       stray = 1'b0;

  always @(posedge clk_in) begin
    if (pend) begin
      if (pcnt == 0) pend <= 1'b0;
      else           pcnt <= pcnt - 1;
    end else if (map_req_valid && map_lat > 0) begin
      pend <= 1'b1;
      pcnt <= map_lat - 1;
    end
  end

  assign map_rsp_valid = stray | ((map_lat == 0) ? map_req_valid : (pend && pcnt == 0));
  assign map_rsp_cell  = maze[map_addr_x][map_addr_y];

  task automatic clear_maze();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) maze[i][j] = 4'd0;
  endtask

  // Reference: plain integer ray march over the maze array.
  logic [9:0] exp_q [$];
  logic [4:0] exp_hx, exp_hy;
  logic       exp_side, exp_to, exp_ov;
  logic [3:0] exp_cell;
  logic [15:0] exp_perp;
  int         exp_steps;
  bit         exp_active = 0;

  function automatic int sat16(input int v, inout bit ov);
    if (v > 32767)  begin ov = 1; return 32767;  end
    if (v < -32768) begin ov = 1; return -32768; end
    return v;
  endfunction

  task automatic model_ray(input int mx0, input int my0, input bit xneg, input bit yneg,
                           input logic [15:0] sx0, input logic [15:0] sy0,
                           input logic [15:0] ddx0, input logic [15:0] ddy0);
    int sx, sy, ddx, ddy, mx, my, perp;
    bit ov, side;
    sx = int'($signed(sx0)); sy = int'($signed(sy0));
    ddx = int'($signed(ddx0)); ddy = int'($signed(ddy0));
    mx = mx0; my = my0; perp = 0; ov = 0; side = 0;
    exp_q.delete();
    exp_cell = 0; exp_to = 0;
    for (int n = 1; n <= MAXS; n++) begin
      if (sx < sy) begin
        perp = sx; sx = sat16(sx + ddx, ov); mx = (mx + (xneg ? 31 : 1)) % 32; side = 0;
      end else begin
        perp = sy; sy = sat16(sy + ddy, ov); my = (my + (yneg ? 31 : 1)) % 32; side = 1;
      end
      exp_q.push_back({5'(mx), 5'(my)});
      exp_steps = n;
      if (maze[mx][my] != 0) begin
        exp_cell = maze[mx][my];
        break;
      end
      if (n == MAXS) exp_to = 1;
    end
    exp_hx = 5'(mx); exp_hy = 5'(my); exp_side = side;
    exp_perp = 16'(perp); exp_ov = ov; exp_active = 1;
  endtask

  // Handshake bookkeeping sampled at the active edge.
  int   cyc = 0;
  logic in_lookup, taken;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      in_lookup <= 1'b0;
      taken     <= 1'b0;
    end else begin
      taken <= result_valid && result_ready;
      if (map_req_valid && !map_rsp_valid) in_lookup <= 1'b1;
      else if (map_rsp_valid)              in_lookup <= 1'b0;
    end
  end

  // Compare process.
  logic [9:0] look_addr, first_addr;
  int         req_count = 0;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      exp_q.delete();
    end else begin
      if (start_valid && start_ready) req_count = 0;
      if (map_req_valid) begin
        if (exp_q.size() == 0) check("req_unexpected", {map_addr_x, map_addr_y}, 32'hFFFF);
        else                   check("req_addr", {map_addr_x, map_addr_y}, exp_q.pop_front());
        req_count++;
        if (req_count == 1) first_addr = {map_addr_x, map_addr_y};
        look_addr = {map_addr_x, map_addr_y};
      end
      if (in_lookup) check("addr_stable", {map_addr_x, map_addr_y}, look_addr);
      if (result_valid && exp_active) begin
        check("hit_x", hit_x, exp_hx);
        check("hit_y", hit_y, exp_hy);
        check("hit_side", hit_side, exp_side);
        check("hit_cell", hit_cell, exp_cell);
        check("perp_dist", perp_dist, exp_perp);
        check("timeout", timeout, exp_to);
        check("ovrflw", ovrflw, exp_ov);
        check("reqs_left", exp_q.size(), 0);
      end
      if (taken) check("result_drop", result_valid, 1'b0);
    end
  end

  logic [4:0]  got_hx, got_hy;
  logic        got_side, got_to, got_ov;
  logic [3:0]  got_cell;
  logic [15:0] got_perp;
  int          got_lat;

  task automatic drive_start(input logic [4:0] mx, input logic [4:0] my, input bit xneg, input bit yneg,
                             input logic [15:0] sx, input logic [15:0] sy,
                             input logic [15:0] ddx, input logic [15:0] ddy, output int t_acc);
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk_in); #1;
      if (start_ready) begin ok = 1; break; end
    end
    if (!ok) check("start_ready_wait", 0, 1);
    map_x_in = mx; map_y_in = my; step_x_in = xneg; step_y_in = yneg;
    side_dist_x_in = sx; side_dist_y_in = sy; delta_dist_x_in = ddx; delta_dist_y_in = ddy;
    start_valid = 1;
    @(posedge clk_in); #1;
    t_acc = cyc;
    start_valid = 0;
  endtask

  task automatic run_ray(input logic [4:0] mx, input logic [4:0] my, input bit xneg, input bit yneg,
                         input logic [15:0] sx, input logic [15:0] sy,
                         input logic [15:0] ddx, input logic [15:0] ddy,
                         input int lat, input int hold, input bit spam);
    int t_acc;
    bit found = 0;
    map_lat = lat;
    model_ray(mx, my, xneg, yneg, sx, sy, ddx, ddy);
    drive_start(mx, my, xneg, yneg, sx, sy, ddx, ddy, t_acc);
    if (spam) begin
      start_valid = 1;
      map_x_in = 5'($urandom); map_y_in = 5'($urandom);
      side_dist_x_in = 16'($urandom); side_dist_y_in = 16'($urandom);
    end
    got_lat = -1;
    for (int k = 0; k < MAXS * (2 + lat) + 20; k++) begin
      @(negedge clk_in);
      if (spam) check("start_ignored", start_ready, 1'b0);
      if (result_valid) begin found = 1; got_lat = cyc - t_acc; break; end
    end
    if (!found) check("result_wait", 0, 1);
    check("latency", got_lat, exp_steps * (2 + lat));
    got_hx = hit_x; got_hy = hit_y; got_side = hit_side; got_cell = hit_cell;
    got_perp = perp_dist; got_to = timeout; got_ov = ovrflw;
    #1 start_valid = 0;
    repeat (hold) @(negedge clk_in);
    #1 result_ready = 1;
    @(posedge clk_in); #1 result_ready = 0;
    @(negedge clk_in);
  endtask

  task automatic t1_checks(input string tag);
    check({tag, "_hx"}, got_hx, 4);
    check({tag, "_hy"}, got_hy, 4);
    check({tag, "_side"}, got_side, 1);
    check({tag, "_perp"}, got_perp, 16'h0100);
    check({tag, "_cell"}, got_cell, 2);
    check({tag, "_to"}, got_to, 0);
    check({tag, "_ov"}, got_ov, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc;
    rst_in = 0; start_valid = 0; result_ready = 0;
    map_x_in = 0; map_y_in = 0; step_x_in = 0; step_y_in = 0;
    side_dist_x_in = 0; side_dist_y_in = 0; delta_dist_x_in = 0; delta_dist_y_in = 0;
    clear_maze();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_result_valid", result_valid, 0);
    check("rst_req", map_req_valid, 0);
    check("rst_perp", perp_dist, 0);
    check("rst_flags", {timeout, ovrflw, hit_side}, 0);
    rst_in = 1;

    // Basic hit.
    maze[4][4] = 2;
    run_ray(3, 3, 0, 0, 16'h0080, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0);
    t1_checks("t1");
    check("t1_lat", got_lat, 4);

    // Tie goes to Y.
    clear_maze(); maze[5][6] = 7;
    run_ray(5, 5, 0, 0, 16'h0200, 16'h0200, 16'h0100, 16'h0100, 0, 2, 0);
    check("t2_side", got_side, 1);
    check("t2_perp", got_perp, 16'h0200);
    check("t2_hy", got_hy, 6);
    check("t2_reqs", req_count, 1);

    // Saturation.
    clear_maze(); maze[11][12] = 9;
    run_ray(10, 10, 0, 0, 16'h7F00, 16'h7FFF, 16'h0200, 16'h0100, 1, 3, 0);
    check("t3_ov", got_ov, 1);
    check("t3_perp", got_perp, 16'h7FFF);
    check("t3_hit", {got_hx, got_hy}, {5'd11, 5'd12});
    check("t3_cell", got_cell, 9);

    // Wrap and timeout.
    clear_maze();
    run_ray(31, 0, 0, 0, 16'h0010, 16'h1000, 16'h0100, 16'h0100, 0, 0, 0);
    check("t4_first_addr", first_addr, 0);
    check("t4_reqs", req_count, 64);
    check("t4_to", got_to, 1);
    check("t4_cell", got_cell, 0);

    // Slow map, stalled consumer, start during ray.
    clear_maze(); maze[4][4] = 2;
    run_ray(3, 3, 0, 0, 16'h0080, 16'h0100, 16'h0100, 16'h0100, 3, 10, 1);
    t1_checks("t5");
    check("t5_lat", got_lat, 10);

    // Reset during LOOKUP with a response still outstanding.
    clear_maze();
    map_lat = 5;
    model_ray(3, 3, 0, 0, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
    drive_start(3, 3, 0, 0, 16'h0080, 16'h0100, 16'h0100, 16'h0100, t_acc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (map_req_valid) break;
    end
    @(posedge clk_in); #2;
    rst_in = 0;
    #1;
    check("t6_rv", result_valid, 0);
    check("t6_req", map_req_valid, 0);
    check("t6_sr", start_ready, 1);
    exp_active = 0;
    @(negedge clk_in);
    @(posedge clk_in); #1 rst_in = 1;
    repeat (2) @(posedge clk_in);
    #1 stray = 1;
    @(posedge clk_in); #1 stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      check("t6_idle", {start_ready, result_valid, map_req_valid}, 3'b100);
    end
    maze[4][4] = 2;
    run_ray(3, 3, 0, 0, 16'h0080, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0);
    t1_checks("t6b");
    check("t6b_lat", got_lat, 4);

    // Randomized rays.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] sx, sy, dx, dy;
      clear_maze();
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++)
          if ($urandom_range(0, 9) == 0) maze[i][j] = 4'($urandom_range(1, 15));
      sx = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800));
      sy = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800));
      dx = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(1, 16'h0400));
      dy = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(1, 16'h0400));
      run_ray(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), sx, sy, dx, dy,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
